rm_violation_reporter: RTL

- Consumer end of a runtime-monitor lane. Samples the rule-result vector produced by the lane's LTL checker automata.
- Detects new rule matches and serialises them, lowest rule index first, into a small FIFO of {rule index, timestamp} records.
- Presents records to the core's trace/CSR side over a valid/ready handshake.
- Keeps sticky per-rule status and a dropped-event counter, and can issue a lane reset back to the checker.

---
 rtl/rm_violation_reporter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rm_violation_reporter.sv
// Turns rising edges on a lane's rule-result vector into {rule, timestamp} records,
// lowest index first, through a small FIFO; also keeps sticky status and a drop counter.
module rm_violation_reporter #(
    parameter int NUM_RULES  = 78,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 16,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = $clog2(NUM_RULES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RULES-1:0] monitor_i,
    input  logic                 clear_i,
    output logic                 lane_reset_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [IDX_W-1:0]     evt_rule_o,
    output logic [TS_W-1:0]      evt_ts_o,
    output logic [NUM_RULES-1:0] sticky_o,
    output logic [CNT_W-1:0]     drop_cnt_o,
    output logic                 fifo_full_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + IDX_W + 1;

    logic [NUM_RULES-1:0] r_mon_q;
    logic [NUM_RULES-1:0] r_pending;
    logic [NUM_RULES-1:0] r_sticky;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic [TS_W-1:0]      r_ts;
    logic [IDX_W-1:0]     r_fifo_rule [FIFO_DEPTH];
    logic [TS_W-1:0]      r_fifo_ts   [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 r_lane_reset;

    logic [NUM_RULES-1:0] w_rise;
    logic [NUM_RULES-1:0] w_svc_onehot;
    logic [NUM_RULES-1:0] w_drop_bits;
    logic [IDX_W-1:0]     w_svc_idx;
    logic [IDX_W:0]       w_drop_num;
    logic [SUM_W-1:0]     w_drop_sum;
    logic [CNT_W-1:0]     w_drop_next;
    logic                 w_full;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_can_push;
    logic                 w_svc;

    // Handshake: a record transfers on any edge where evt_valid_o and evt_ready_i are both
    // high; evt_valid_o never depends on evt_ready_i and the head is stable until popped.
    assign w_rise     = monitor_i & ~r_mon_q;
    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & evt_ready_i;
    assign w_can_push = ~w_full | w_pop;
    assign w_svc      = (|r_pending) & w_can_push;

    always_comb begin
        w_svc_idx    = '0;
        w_svc_onehot = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (r_pending[i]) w_svc_idx = IDX_W'(i);
        end
        if (w_svc) w_svc_onehot[w_svc_idx] = 1'b1;
    end

    // A second rise on a still-pending rule is lost, unless that rule leaves pending this edge.
    assign w_drop_bits = w_rise & r_pending & ~w_svc_onehot;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            w_drop_num = w_drop_num + (IDX_W+1)'(w_drop_bits[i]);
        end
        w_drop_sum  = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_num);
        w_drop_next = (w_drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                           : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mon_q      <= '0;
            r_pending    <= '0;
            r_sticky     <= '0;
            r_drop_cnt   <= '0;
            r_ts         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_lane_reset <= 1'b0;
        end else begin
            r_mon_q      <= monitor_i;
            r_ts         <= r_ts + TS_W'(1);
            r_lane_reset <= clear_i;
            if (clear_i) begin
                r_pending  <= '0;
                r_sticky   <= '0;
                r_drop_cnt <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_pending  <= (r_pending & ~w_svc_onehot) | w_rise;
                r_sticky   <= r_sticky | w_rise;
                r_drop_cnt <= w_drop_next;
                if (w_svc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_svc, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Record storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_svc && !clear_i) begin
            r_fifo_rule[r_wr_ptr] <= w_svc_idx;
            r_fifo_ts[r_wr_ptr]   <= r_ts + TS_W'(1);
        end
    end

    assign evt_valid_o  = w_valid;
    assign evt_rule_o   = w_valid ? r_fifo_rule[r_rd_ptr] : '0;
    assign evt_ts_o     = w_valid ? r_fifo_ts[r_rd_ptr] : '0;
    assign sticky_o     = r_sticky;
    assign drop_cnt_o   = r_drop_cnt;
    assign fifo_full_o  = w_full;
    assign lane_reset_o = r_lane_reset;

endmodule
